mem_port_master: RTL

//  Requester-side controller for the single-port MemGen_16_10 SRAM wrapper.

---
 rtl/mem_port_pkg.sv | 23 ++
 rtl/mem_port_master_if.sv | 52 +++++
 rtl/mem_rsp_fifo.sv | 47 ++++
 rtl/mem_port_master.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared types and default widths for the MemGen_16_10 requester-side controller.
// Holds the FSM state encoding and the request record used by callers of mem_port_master.
package mem_port_pkg;

  localparam int DFLT_ADDR_W = 10;
  localparam int DFLT_DATA_W = 16;
  localparam int DFLT_LEN_W  = 4;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_READ
  } state_t;

  typedef struct packed {
    logic                   write;
    logic [DFLT_ADDR_W-1:0] addr;
    logic [DFLT_LEN_W-1:0]  len;
    logic [DFLT_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_port_master_if.sv
// Request/response channel between core logic and the controller, and the SRAM strobe bus.
// Modports: master drives the transaction, slave answers it.
interface mem_req_if
  import mem_port_pkg::*;
#(
  parameter int ADDR_W = DFLT_ADDR_W,
  parameter int DATA_W = DFLT_DATA_W,
  parameter int LEN_W  = DFLT_LEN_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;

  modport master (
    output req_valid, req_write, req_addr, req_len, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_last
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_len, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_last
  );
endinterface

interface mem_sram_if
  import mem_port_pkg::*;
#(
  parameter int ADDR_W = DFLT_ADDR_W,
  parameter int DATA_W = DFLT_DATA_W
);
  logic              chip_en;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output chip_en, wr_en, rd_en, addr, wr_data,
    input  rd_data
  );
  modport slave (
    input  chip_en, wr_en, rd_en, addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/mem_rsp_fifo.sv
// Synchronous response FIFO; head is presented combinationally, push visible next cycle.
// Push is dropped only when full with no pop; push+pop together is legal when full or empty.
module mem_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = store[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Payload storage needs no reset; emptiness is tracked by the pointers alone.
  always_ff @(posedge clock) begin
    if (push_ok) store[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/mem_port_master.sv
// Requester-side controller for the MemGen_16_10 SRAM: strobes lag the FSM by one cycle, reads stream 1 beat/cycle.
// Read issue is credit-gated on response FIFO space, so read data is never dropped. MEM_MASTER_INIT_CLEAR_EN adds a post-reset zero fill.
module mem_port_master
  import mem_port_pkg::*;
#(
  parameter int ADDR_W    = DFLT_ADDR_W,
  parameter int DATA_W    = DFLT_DATA_W,
  parameter int RD_LAT    = 1,
  parameter int RSP_DEPTH = 4,
  parameter int LEN_W     = DFLT_LEN_W
) (
  input  logic        clock,
  input  logic        reset_n,
  mem_req_if.slave    req_bus,
  mem_sram_if.master  mem_bus,
  output logic        busy
);
  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

`ifdef MEM_MASTER_INIT_CLEAR_EN
  localparam state_t RESET_STATE = ST_INIT;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t            state;
  state_t            state_nxt;
  logic              run_q;
  logic              accept;
  logic              issue_rd;
  logic              has_credit;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] init_addr;
  logic [LEN_W-1:0]  beats_left;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_head;
  logic              push;
  logic              pop;
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_last;
  logic              chip_en_q;
  logic              wr_en_q;
  logic              rd_en_q;
  logic              rd_last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wr_data_q;

  // Beats already issued still need a FIFO slot, so they count against credit.
  assign has_credit = ({1'b0, fifo_count} + {1'b0, inflight}) < SUM_W'(RSP_DEPTH);

  // run_q keeps req_ready low while reset is held and for the first cycle after.
  assign req_bus.req_ready = (state == ST_IDLE) && run_q;
  assign accept            = req_bus.req_valid && req_bus.req_ready;

  always_comb begin
    state_nxt = state;
    issue_rd  = 1'b0;
    case (state)
      ST_INIT:  if (init_addr == '1) state_nxt = ST_IDLE;
      ST_IDLE:  if (accept) state_nxt = req_bus.req_write ? ST_WRITE : ST_READ;
      ST_WRITE: state_nxt = ST_IDLE;
      ST_READ: begin
        if (has_credit) begin
          issue_rd = 1'b1;
          if (beats_left == '0) state_nxt = ST_IDLE;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= RESET_STATE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      rd_addr    <= '0;
      beats_left <= '0;
      init_addr  <= '0;
      inflight   <= '0;
      chip_en_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_last_q  <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        cap_addr   <= req_bus.req_addr;
        cap_wdata  <= req_bus.req_wdata;
        rd_addr    <= req_bus.req_addr;
        beats_left <= req_bus.req_len;
      end else if (issue_rd) begin
        rd_addr    <= rd_addr + ADDR_W'(1);
        beats_left <= beats_left - LEN_W'(1);
      end
      if (state == ST_INIT) init_addr <= init_addr + ADDR_W'(1);

      inflight  <= inflight + CNT_W'(issue_rd) - CNT_W'(push);
      wr_en_q   <= (state == ST_WRITE) || (state == ST_INIT);
      rd_en_q   <= issue_rd;
      chip_en_q <= (state == ST_WRITE) || (state == ST_INIT) || issue_rd;
      rd_last_q <= issue_rd && (beats_left == '0);

      if (state == ST_INIT) begin
        addr_q    <= init_addr;
        wr_data_q <= '0;
      end else if (state == ST_WRITE) begin
        addr_q    <= cap_addr;
        wr_data_q <= cap_wdata;
      end else if (issue_rd) begin
        addr_q    <= rd_addr;
      end
    end
  end

  // Tracks which SRAM cycles will deliver rd_data, RD_LAT edges after rd_en is sampled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe_vld  <= '0;
      pipe_last <= '0;
    end else begin
      pipe_vld[0]  <= rd_en_q;
      pipe_last[0] <= rd_last_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  assign push = pipe_vld[RD_LAT-1];
  assign pop  = req_bus.rsp_valid && req_bus.rsp_ready;

  mem_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({pipe_last[RD_LAT-1], mem_bus.rd_data}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign req_bus.rsp_valid = !fifo_empty;
  assign req_bus.rsp_data  = fifo_head[DATA_W-1:0] & {DATA_W{!fifo_empty}};
  assign req_bus.rsp_last  = fifo_head[DATA_W] && !fifo_empty;

  assign mem_bus.chip_en = chip_en_q;
  assign mem_bus.wr_en   = wr_en_q;
  assign mem_bus.rd_en   = rd_en_q;
  assign mem_bus.addr    = addr_q;
  assign mem_bus.wr_data = wr_data_q;

  assign busy = (state != ST_IDLE) || (inflight != '0) || !fifo_empty || wr_en_q;

endmodule
